// File: rtl/warmboot_seq.sv
// ============================================================================
// Module      : warmboot_seq
// Description : Bus-programmable N-image warm-boot sequencer for SB_WARMBOOT.
//               Optional watchdog fallback enabled by WARMBOOT_WDT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module warmboot_seq #(
    parameter int         NUM_IMAGES   = 4,
    parameter logic [7:0] KEY          = 8'hA5,
    parameter int         ARM_TIMEOUT  = 255,
    parameter int         SETUP_CYCLES = 16,
    parameter int         PULSE_CYCLES = 4,
    parameter int         WDT_CYCLES   = 2**20
) (
    input  logic       CLK1,
    input  logic       RESET,
    input  logic       WR_STB,
    input  logic [1:0] WR_ADDR,
    input  logic [7:0] WR_DATA,
    output logic [7:0] RD_DATA,
    output logic       BUSY,
    output logic       S0,
    output logic       S1,
    output logic       BOOT
);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_ARMED = 3'd1;
    localparam logic [2:0] c_SETUP = 3'd2;
    localparam logic [2:0] c_PULSE = 3'd3;
    localparam logic [2:0] c_DONE  = 3'd4;

    localparam int c_ARM_W   = $clog2(ARM_TIMEOUT + 1);
    localparam int c_SEQ_MAX = (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
    localparam int c_SEQ_W   = $clog2(c_SEQ_MAX + 1);

    localparam logic [7:0]         c_NUM_IMG  = 8'(NUM_IMAGES);
    localparam logic [c_ARM_W-1:0] c_ARM_LD   = c_ARM_W'(ARM_TIMEOUT);
    localparam logic [c_SEQ_W-1:0] c_SETUP_LD = c_SEQ_W'(SETUP_CYCLES);
    localparam logic [c_SEQ_W-1:0] c_PULSE_LD = c_SEQ_W'(PULSE_CYCLES - 1);

    generate
        if (NUM_IMAGES < 2 || NUM_IMAGES > 4 || ARM_TIMEOUT < 1 || SETUP_CYCLES < 1 ||
            PULSE_CYCLES < 1 || WDT_CYCLES < 1) begin : g_param_check
            $error("warmboot_seq: parameter out of range");
        end
    endgenerate

    logic [2:0]         r_state;
    logic [1:0]         r_image;
    logic               r_err;
    logic               r_busy;
    logic               r_boot;
    logic [c_ARM_W-1:0] r_arm_cnt;
    logic [c_SEQ_W-1:0] r_seq_cnt;

    logic w_wr_key;
    logic w_wr_img;
    logic w_wr_kick;
    logic w_img_ok;
    logic w_wdt_live;
    logic w_wdt_expire;
    logic w_wdt_fired;

    assign w_wr_key   = WR_STB && (WR_ADDR == 2'd0);
    assign w_wr_img   = WR_STB && (WR_ADDR == 2'd1);
    assign w_wr_kick  = WR_STB && (WR_ADDR == 2'd2);
    assign w_img_ok   = (WR_DATA < c_NUM_IMG);
    assign w_wdt_live = (r_state == c_IDLE) || (r_state == c_ARMED);

`ifdef WARMBOOT_WDT_EN
    localparam int                 c_WDT_W    = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES) : 1;
    localparam logic [c_WDT_W-1:0] c_WDT_LAST = c_WDT_W'(WDT_CYCLES - 1);

    // Counts elapsed cycles upward so the reset value is zero; expiry is the last count.
    logic [c_WDT_W-1:0] r_wdt_cnt;
    logic               r_wdt_fired;

    assign w_wdt_expire = w_wdt_live && !w_wr_kick && (r_wdt_cnt == c_WDT_LAST);
    assign w_wdt_fired  = r_wdt_fired;

    always_ff @(posedge CLK1 or posedge RESET) begin
        if (RESET) begin
            r_wdt_cnt   <= '0;
            r_wdt_fired <= 1'b0;
        end else if (w_wdt_live) begin
            if (w_wr_kick) begin
                r_wdt_cnt <= '0;
            end else if (r_wdt_cnt != c_WDT_LAST) begin
                r_wdt_cnt <= r_wdt_cnt + 1'b1;
            end
            if (w_wdt_expire) begin
                r_wdt_fired <= 1'b1;
            end
        end
    end
`else
    assign w_wdt_expire = 1'b0;
    assign w_wdt_fired  = 1'b0;
`endif

    always_ff @(posedge CLK1 or posedge RESET) begin
        if (RESET) begin
            r_state   <= c_IDLE;
            r_image   <= 2'd0;
            r_err     <= 1'b0;
            r_busy    <= 1'b0;
            r_boot    <= 1'b0;
            r_arm_cnt <= '0;
            r_seq_cnt <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_wdt_expire) begin
                        r_state   <= c_SETUP;
                        r_image   <= 2'd0;
                        r_busy    <= 1'b1;
                        r_seq_cnt <= c_SETUP_LD;
                    end else if (w_wr_key && (WR_DATA == KEY)) begin
                        r_state   <= c_ARMED;
                        r_err     <= 1'b0;
                        r_arm_cnt <= c_ARM_LD;
                    end
                end
                c_ARMED: begin
                    // Priority: watchdog, then image/key writes, then arm timeout.
                    if (w_wdt_expire) begin
                        r_state   <= c_SETUP;
                        r_image   <= 2'd0;
                        r_busy    <= 1'b1;
                        r_seq_cnt <= c_SETUP_LD;
                    end else if (w_wr_img) begin
                        if (w_img_ok) begin
                            r_state   <= c_SETUP;
                            r_image   <= WR_DATA[1:0];
                            r_busy    <= 1'b1;
                            r_seq_cnt <= c_SETUP_LD;
                        end else begin
                            r_state <= c_IDLE;
                            r_err   <= 1'b1;
                        end
                    end else if (w_wr_key) begin
                        r_state <= c_IDLE;
                    end else if (r_arm_cnt <= c_ARM_W'(1)) begin
                        r_state <= c_IDLE;
                    end else begin
                        r_arm_cnt <= r_arm_cnt - 1'b1;
                    end
                end
                c_SETUP: begin
                    if (r_seq_cnt == '0) begin
                        r_state   <= c_PULSE;
                        r_boot    <= 1'b1;
                        r_seq_cnt <= c_PULSE_LD;
                    end else begin
                        r_seq_cnt <= r_seq_cnt - 1'b1;
                    end
                end
                c_PULSE: begin
                    if (r_seq_cnt == '0) begin
                        r_state <= c_DONE;
                        r_boot  <= 1'b0;
                    end else begin
                        r_seq_cnt <= r_seq_cnt - 1'b1;
                    end
                end
                c_DONE: begin
                    r_boot <= 1'b0;
                end
                default: begin
                    r_state <= c_IDLE;
                    r_boot  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign RD_DATA = {r_busy, (r_state == c_ARMED), r_err, w_wdt_fired, 2'b00, r_image};
    assign BUSY    = r_busy;
    assign S0      = r_image[0];
    assign S1      = r_image[1];
    assign BOOT    = r_boot;

endmodule

`default_nettype wire
